// File: rtl/mat_seq.sv
// Multi-cycle sequencer for 4x4 matrix-register MUL / MAC / ADD instructions.
// All results are buffered before commit, so the destination may alias a source.
module mat_seq #(
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [1:0]              op,
   input  logic [$clog2(NREG)-1:0] rs1,
   input  logic [$clog2(NREG)-1:0] rs2,
   input  logic [$clog2(NREG)-1:0] rd,
   input  logic                    flush,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [$clog2(NREG)-1:0] r1_m,
   output logic [1:0]              r1_i,
   output logic [1:0]              r1_j,
   input  logic [DW-1:0]           r1_data,
   output logic [$clog2(NREG)-1:0] r2_m,
   output logic [1:0]              r2_i,
   output logic [1:0]              r2_j,
   input  logic [DW-1:0]           r2_data,
   output logic [$clog2(NREG)-1:0] r3_m,
   output logic [1:0]              r3_i,
   output logic [1:0]              r3_j,
   input  logic [DW-1:0]           r3_data,
   output logic                    we,
   output logic [$clog2(NREG)-1:0] w_m,
   output logic [1:0]              w_i,
   output logic [1:0]              w_j,
   output logic [DW-1:0]           w_data
);
   localparam int IW = $clog2(NREG);

   typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

   state_t          state, state_n;
   logic [1:0]      op_q;
   logic [IW-1:0]   rs1_q, rs2_q, rd_q;
   logic [1:0]      i, j, k;
   logic [DW-1:0]   acc;
   logic [DW-1:0]   res_buf [16];

   logic            is_add, accept, calc_last, write_last;
   logic [DW-1:0]   prod, base, sum;

   assign is_add     = (op_q == 2'b10);
   assign accept     = (state == IDLE) && start && !flush;
   assign write_last = (i == 2'd3) && (j == 2'd3);
   assign calc_last  = write_last && (is_add || (k == 2'd3));

   assign prod = r1_data * r2_data;
   assign base = (op_q == 2'b01) ? r3_data : '0;
   assign sum  = is_add ? (r1_data + r2_data)
                        : (((k == 2'd0) ? base : acc) + prod);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (accept) state_n = (op == 2'b11) ? DONE : CALC;
         CALC:  if (flush) state_n = IDLE;
                else if (calc_last) state_n = WRITE;
         WRITE: if (flush) state_n = IDLE;
                else if (write_last) state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Element write in the flush cycle itself is suppressed, so an abort
   // never commits the element it coincides with.
   always_comb begin
      busy   = (state != IDLE);
      done   = 1'b0;
      err    = 1'b0;
      r1_m   = '0; r1_i = '0; r1_j = '0;
      r2_m   = '0; r2_i = '0; r2_j = '0;
      r3_m   = '0; r3_i = '0; r3_j = '0;
      we     = 1'b0;
      w_m    = '0; w_i = '0; w_j = '0;
      w_data = '0;
      case (state)
         CALC: begin
            r1_m = rs1_q; r1_i = i;                r1_j = is_add ? j : k;
            r2_m = rs2_q; r2_i = is_add ? i : k;   r2_j = j;
            r3_m = rd_q;  r3_i = i;                r3_j = j;
         end
         WRITE: begin
            we     = !flush;
            w_m    = rd_q;
            w_i    = i;
            w_j    = j;
            w_data = res_buf[{i, j}];
         end
         DONE: begin
            done = 1'b1;
            err  = (op_q == 2'b11);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         op_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         rd_q  <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: if (accept) begin
               op_q  <= op;
               rs1_q <= rs1;
               rs2_q <= rs2;
               rd_q  <= rd;
               i     <= '0;
               j     <= '0;
               k     <= '0;
            end
            CALC: begin
               if (is_add) begin
                  {i, j} <= {i, j} + 4'd1;
               end else begin
                  k <= k + 2'd1;
                  if (k == 2'd3) {i, j} <= {i, j} + 4'd1;
               end
            end
            WRITE: {i, j} <= {i, j} + 4'd1;
            default: ;
         endcase
      end
   end

   // The result buffer deliberately survives reset.
   always_ff @(posedge clk) begin
      if (state == CALC) begin
         acc <= sum;
         if (is_add || (k == 2'd3)) res_buf[{i, j}] <= sum;
      end
   end
endmodule

// File: tb/tb_mat_seq.sv
// Directed self-checking bench for mat_seq with a behavioural matrix register file.
module tb_mat_seq;
   logic        clk, rst_n, start, flush;
   logic [1:0]  op;
   logic [4:0]  rs1, rs2, rd;
   logic        busy, done, err, we;
   logic [4:0]  r1_m, r2_m, r3_m, w_m;
   logic [1:0]  r1_i, r1_j, r2_i, r2_j, r3_i, r3_j, w_i, w_j;
   logic [31:0] r1_data, r2_data, r3_data, w_data;

   logic [31:0] mem [32][4][4];

   int checks = 0;
   int fails  = 0;

   int          wcnt;
   logic [31:0] wdat [64];
   logic [4:0]  wm   [64];
   logic [3:0]  widx [64];
   int          wcyc [64];
   int          done_cyc, err_cnt, busy_first, busy_last, busy_cnt;
   logic        rst_snap;
   logic [31:0] exp_data [16];

   mat_seq #(.DW(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
      .busy(busy), .done(done), .err(err),
      .r1_m(r1_m), .r1_i(r1_i), .r1_j(r1_j), .r1_data(r1_data),
      .r2_m(r2_m), .r2_i(r2_i), .r2_j(r2_j), .r2_data(r2_data),
      .r3_m(r3_m), .r3_i(r3_i), .r3_j(r3_j), .r3_data(r3_data),
      .we(we), .w_m(w_m), .w_i(w_i), .w_j(w_j), .w_data(w_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign r1_data = mem[r1_m][r1_i][r1_j];
   assign r2_data = mem[r2_m][r2_i][r2_j];
   assign r3_data = mem[r3_m][r3_i][r3_j];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // mode: 0 const v, 1 identity, 2 i*4+j+1, 3 i, 4 j
   task automatic fillMat(input int m, input int mode, input logic [31:0] v);
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            case (mode)
               0: mem[m][a][b] = v;
               1: mem[m][a][b] = (a == b) ? 32'd1 : 32'd0;
               2: mem[m][a][b] = 32'(a * 4 + b + 1);
               3: mem[m][a][b] = 32'(a);
               default: mem[m][a][b] = 32'(b);
            endcase
   endtask

   // mode: 0 const v, 2 n+1, 5 i+j
   task automatic setExp(input int mode, input logic [31:0] v);
      for (int n = 0; n < 16; n++)
         case (mode)
            0: exp_data[n] = v;
            2: exp_data[n] = 32'(n + 1);
            default: exp_data[n] = 32'(n / 4 + n % 4);
         endcase
   endtask

   task automatic applyStimulus(input logic [1:0] op_v, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input int ncyc, input int flush_at,
                                input int restart_at, input logic [4:0] rd_alt, input int rst_at);
      wcnt = 0; done_cyc = -1; err_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
      rst_snap = 1'b0;
      @(negedge clk);
      start = 1'b1; op = op_v; rs1 = a; rs2 = b; rd = c; flush = 1'b0; rst_n = 1'b1;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         @(negedge clk);
         start = (cyc == restart_at);
         if (cyc == restart_at) begin
            rd = rd_alt; rs1 = rd_alt; op = 2'b00;
         end
         flush = (cyc == flush_at);
         rst_n = (cyc != rst_at);
         #1;
         if (we && wcnt < 64) begin
            wdat[wcnt] = w_data; wm[wcnt] = w_m; widx[wcnt] = {w_i, w_j}; wcyc[wcnt] = cyc;
            wcnt++;
         end
         if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
         end
         if (done) done_cyc = cyc;
         if (err) err_cnt++;
         if (cyc == rst_at + 1)
            rst_snap = |{busy, done, err, we, r1_m, r1_i, r1_j, r2_m, r2_i, r2_j,
                         r3_m, r3_i, r3_j, w_m, w_i, w_j, w_data};
      end
      start = 1'b0; flush = 1'b0; rst_n = 1'b1;
   endtask

   task automatic checkWrites(input string tag, input int n_exp, input int first_cyc, input logic [4:0] m_exp);
      checkOutput({tag, "_wcount"}, wcnt, n_exp);
      for (int n = 0; n < n_exp && n < wcnt; n++) begin
         checkOutput($sformatf("%s_data%0d", tag, n), wdat[n], exp_data[n]);
         checkOutput($sformatf("%s_m%0d", tag, n), {27'd0, wm[n]}, {27'd0, m_exp});
         checkOutput($sformatf("%s_idx%0d", tag, n), {28'd0, widx[n]}, 32'(n));
         checkOutput($sformatf("%s_cyc%0d", tag, n), wcyc[n], first_cyc + n);
      end
   endtask

   initial begin
      start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; rd = '0; rst_n = 1'b0;
      for (int m = 0; m < 32; m++) fillMat(m, 0, 32'd0);

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done_err_we", {29'd0, done, err, we}, 32'd0);
      checkOutput("reset_raddr", {17'd0, r1_m, r1_i, r1_j, r2_m, r2_i, r2_j}, 32'd0);
      checkOutput("reset_r3addr", {23'd0, r3_m, r3_i, r3_j}, 32'd0);
      checkOutput("reset_waddr", {23'd0, w_m, w_i, w_j}, 32'd0);
      checkOutput("reset_wdata", w_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] MUL identity * 1..16");
      fillMat(1, 1, 0); fillMat(2, 2, 0);
      applyStimulus(2'b00, 5'd1, 5'd2, 5'd3, 90, -1, -1, 5'd0, -1);
      setExp(2, 0);
      checkWrites("mul", 16, 65, 5'd3);
      checkOutput("mul_done_cyc", done_cyc, 81);
      checkOutput("mul_busy_first", busy_first, 1);
      checkOutput("mul_busy_last", busy_last, 81);
      checkOutput("mul_busy_cnt", busy_cnt, 81);
      checkOutput("mul_err", err_cnt, 0);

      $display("[TB] MAC 5 + 2*3 summed");
      fillMat(5, 0, 32'd2); fillMat(6, 0, 32'd3); fillMat(7, 0, 32'd5);
      applyStimulus(2'b01, 5'd5, 5'd6, 5'd7, 85, -1, -1, 5'd0, -1);
      setExp(0, 32'd29);
      checkWrites("mac", 16, 65, 5'd7);
      checkOutput("mac_done_cyc", done_cyc, 81);

      $display("[TB] MAC wrap-around");
      fillMat(5, 0, 32'h7FFF_FFFF); fillMat(6, 0, 32'd2); fillMat(7, 0, 32'd0);
      applyStimulus(2'b01, 5'd5, 5'd6, 5'd7, 85, -1, -1, 5'd0, -1);
      setExp(0, 32'hFFFF_FFF8);
      checkWrites("macwrap", 16, 65, 5'd7);

      $display("[TB] MUL aliasing rd=rs1=rs2");
      fillMat(4, 0, 32'd1);
      applyStimulus(2'b00, 5'd4, 5'd4, 5'd4, 85, -1, -1, 5'd0, -1);
      setExp(0, 32'd4);
      checkWrites("alias", 16, 65, 5'd4);
      checkOutput("alias_done_cyc", done_cyc, 81);

      $display("[TB] ADD with ignored start at cycle 5");
      fillMat(10, 3, 0); fillMat(11, 4, 0);
      applyStimulus(2'b10, 5'd10, 5'd11, 5'd12, 40, -1, 5, 5'd9, -1);
      setExp(5, 0);
      checkWrites("add", 16, 17, 5'd12);
      checkOutput("add_done_cyc", done_cyc, 33);
      checkOutput("add_busy_cnt", busy_cnt, 33);

      $display("[TB] reserved op");
      applyStimulus(2'b11, 5'd1, 5'd2, 5'd3, 5, -1, -1, 5'd0, -1);
      checkOutput("rsv_done_cyc", done_cyc, 1);
      checkOutput("rsv_err_cnt", err_cnt, 1);
      checkOutput("rsv_wcount", wcnt, 0);
      checkOutput("rsv_busy_cnt", busy_cnt, 1);

      $display("[TB] flush during WRITE");
      applyStimulus(2'b00, 5'd1, 5'd2, 5'd3, 90, 70, -1, 5'd0, -1);
      setExp(2, 0);
      checkWrites("flush", 5, 65, 5'd3);
      checkOutput("flush_busy_last", busy_last, 70);
      checkOutput("flush_done_cyc", done_cyc, -1);

      $display("[TB] reset during MAC then fresh MAC");
      fillMat(5, 0, 32'd2); fillMat(6, 0, 32'd3); fillMat(7, 0, 32'd5);
      applyStimulus(2'b01, 5'd5, 5'd6, 5'd7, 25, -1, -1, 5'd0, 20);
      checkOutput("rst_outputs_zero", {31'd0, rst_snap}, 32'd0);
      checkOutput("rst_busy_last", busy_last, 20);
      checkOutput("rst_wcount", wcnt, 0);
      checkOutput("rst_done_cyc", done_cyc, -1);
      applyStimulus(2'b01, 5'd5, 5'd6, 5'd7, 85, -1, -1, 5'd0, -1);
      setExp(0, 32'd29);
      checkWrites("postrst", 16, 65, 5'd7);
      checkOutput("postrst_done_cyc", done_cyc, 81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end
endmodule
